// File: rtl/prod_bcd_pkg.sv
// Shared definitions for the product binary-to-BCD converter.
package prod_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int BCD_DW = 4;

   // Smallest digit count whose decimal range covers every W-bit value.
   function automatic int nd_for_w(input int w);
      longint unsigned maxv;
      longint unsigned lim;
      int              nd;
      maxv = (64'd1 << w) - 64'd1;
      lim  = 64'd10;
      nd   = 1;
      for (int unsigned i = 0; i < 20; i++) begin
         if (lim <= maxv) begin
            nd  = nd + 1;
            lim = lim * 64'd10;
         end
      end
      return nd;
   endfunction

endpackage

// File: rtl/prod_bcd_conv_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_digit_adj
   import prod_bcd_pkg::*;
(
   input  logic [BCD_DW-1:0] din_i,
   output logic [BCD_DW-1:0] dout_o
);

   assign dout_o = (din_i >= 4'd5) ? 4'(din_i + 4'd3) : din_i;

endmodule

// File: rtl/prod_bcd_conv.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock.
// Define PROD_BCD_BLANK_EN to add the registered leading-zero blank output.
module prod_bcd_conv
   import prod_bcd_pkg::*;
#(
   parameter int W  = 8,
   parameter int ND = nd_for_w(W)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [W-1:0]         bin,
   output logic                 busy,
   output logic                 done,
   output logic [BCD_DW*ND-1:0] bcd
`ifdef PROD_BCD_BLANK_EN
   ,
   output logic [ND-1:0]        blank
`endif
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam int DW = BCD_DW * ND;

   state_e          state_q, state_d;
   logic [DW+W-1:0] sr_q, sr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   bcd_q, bcd_d;
   logic [DW-1:0]   adj;
   logic [DW+W-1:0] shifted;

   for (genvar g = 0; g < ND; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din_i  (sr_q[W + g*BCD_DW +: BCD_DW]),
         .dout_o (adj[g*BCD_DW +: BCD_DW])
      );
   end

   assign shifted = {adj, sr_q[W-1:0]} << 1;

`ifdef PROD_BCD_BLANK_EN
   logic [ND-1:0] blank_q, blank_d, blank_fin;
   logic          zr;

   // Running AND from the most significant digit down; ones digit always shown.
   always_comb begin
      zr        = 1'b1;
      blank_fin = '0;
      for (int unsigned k = 0; k < unsigned'(ND); k++) begin
         zr = zr & (shifted[W + (ND-1-int'(k))*BCD_DW +: BCD_DW] == '0);
         blank_fin[ND-1-int'(k)] = zr;
      end
      blank_fin[0] = 1'b0;
   end
`endif

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
`ifdef PROD_BCD_BLANK_EN
      blank_d = blank_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               sr_d    = {{DW{1'b0}}, bin};
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sr_d  = shifted;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W-1)) begin
               state_d = DONE;
               bcd_d   = shifted[DW+W-1:W];
`ifdef PROD_BCD_BLANK_EN
               blank_d = blank_fin;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
`ifdef PROD_BCD_BLANK_EN
         blank_q <= {ND{1'b1}} << 1;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
`ifdef PROD_BCD_BLANK_EN
         blank_q <= blank_d;
`endif
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign bcd  = bcd_q;
`ifdef PROD_BCD_BLANK_EN
   assign blank = blank_q;
`endif

endmodule

// File: tb/tb_prod_bcd_conv.sv
// Directed bench for prod_bcd_conv; builds with or without PROD_BCD_BLANK_EN.
module tb_prod_bcd_conv;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  bin;
   logic        busy;
   logic        done;
   logic [11:0] bcd;
`ifdef PROD_BCD_BLANK_EN
   logic [2:0]  blank;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   prod_bcd_conv #(.W(8), .ND(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
`ifdef PROD_BCD_BLANK_EN
      ,
      .blank (blank)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input int lim);
      int i;
      i = 0;
      while (!done && i < lim) begin
         @(negedge clk);
         i++;
      end
      if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic conv(input logic [7:0] v);
      @(negedge clk);
      bin   = v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(20);
   endtask

   function automatic logic [11:0] to_bcd(input int p);
      return {4'(p / 100), 4'((p / 10) % 10), 4'(p % 10)};
   endfunction

   initial begin
      int          lat;
      int          ndone;
      int          p;
      logic [11:0] e;
      logic [7:0]  seq [3];

      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_bcd", {20'd0, bcd}, 32'h000);
`ifdef PROD_BCD_BLANK_EN
      chk("rst_blank", {29'd0, blank}, 32'b110);
`endif
      rst = 1'b0;

      // 255: latency, result, busy drop
      @(negedge clk);
      bin   = 8'd255;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(negedge clk);
         if (done) lat = i;
      end
      chk("latency", lat, 8);
      chk("bcd_255", {20'd0, bcd}, 32'h255);
      @(negedge clk);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      chk("done_one_cycle", {31'd0, done}, 32'd0);

      // start held high: back-to-back conversions
      seq[0] = 8'd0;
      seq[1] = 8'd99;
      seq[2] = 8'd100;
      bin   = seq[0];
      start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         wait_done(30);
         chk($sformatf("b2b_%0d", seq[k]), {20'd0, bcd}, {20'd0, to_bcd(int'(seq[k]))});
         if (k < 2) bin = seq[k+1];
         @(negedge clk);
      end
      start = 1'b0;
      repeat (12) @(negedge clk);
      chk("b2b_idle", {31'd0, busy}, 32'd0);

      // multiplier product sweep
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            p = a * b;
            e = to_bcd(p);
            conv(8'(p));
            chk($sformatf("prod_%0dx%0d", a, b), {20'd0, bcd}, {20'd0, e});
`ifdef PROD_BCD_BLANK_EN
            chk($sformatf("blank_%0dx%0d", a, b), {29'd0, blank},
                {29'd0, (e[11:8] == 4'd0), (e[11:4] == 8'd0), 1'b0});
`endif
         end
      end

      // requests while busy are dropped
      @(negedge clk);
      bin   = 8'd42;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 1; i <= 25; i++) begin
         start = (i == 2 || i == 5);
         bin   = 8'd77;
         @(negedge clk);
         if (done) ndone++;
      end
      start = 1'b0;
      chk("busy_start_ignored", ndone, 1);
      chk("bcd_42", {20'd0, bcd}, 32'h042);

      // reset mid-conversion
      bin   = 8'd200;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_bcd", {20'd0, bcd}, 32'h000);
      rst   = 1'b0;
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort_no_done", ndone, 0);

      // reset together with start
      rst   = 1'b1;
      start = 1'b1;
      bin   = 8'd5;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_start_busy", {31'd0, busy}, 32'd0);

`ifdef PROD_BCD_BLANK_EN
      conv(8'd7);
      chk("blank_7", {29'd0, blank}, 32'b110);
      conv(8'd40);
      chk("blank_40", {29'd0, blank}, 32'b100);
      conv(8'd0);
      chk("blank_0", {29'd0, blank}, 32'b110);
      conv(8'd105);
      chk("blank_105", {29'd0, blank}, 32'b000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
